// File: rtl/bquad_pow_seq_if.sv
// bquad_pow_seq_if: request/response bundle for the GF(2^233) squaring-chain
// sequencer.
//   start  : request; taken only while the sequencer is not running
//   a_in   : 233-bit field element operand
//   n_in   : NW-bit number of squarings
//   abort  : (only when BQSEQ_ABORT_EN is defined) cancel a running chain
//   busy   : squaring passes in progress
//   done   : one-cycle pulse, result valid
//   result : a^(2^n), held until the next accepted start
// Optional macro: BQSEQ_ABORT_EN adds the abort signal.
interface bquad_pow_seq_if #(
  parameter int NW = 8
);
  logic          start;
  logic [232:0]  a_in;
  logic [NW-1:0] n_in;
`ifdef BQSEQ_ABORT_EN
  logic          abort;
`endif
  logic          busy;
  logic          done;
  logic [232:0]  result;

  modport master (
`ifdef BQSEQ_ABORT_EN
    output abort,
`endif
    output start, a_in, n_in,
    input  busy, done, result
  );

  modport slave (
`ifdef BQSEQ_ABORT_EN
    input  abort,
`endif
    input  start, a_in, n_in,
    output busy, done, result
  );
endinterface

// File: rtl/bquad_pow_seq.sv
// bquad_pow_seq: multi-cycle sequencer computing a^(2^n) in GF(2^233) with
// field polynomial x^233 + x^74 + 1, n = 0..2^NW-1. Each RUN cycle pushes the
// accumulator through one bquadblk pass of up to MAX_STEP squarings.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : bquad_pow_seq_if slave (start, a_in, n_in, busy, done, result
//         and, with BQSEQ_ABORT_EN defined, abort)
// Optional macro: BQSEQ_ABORT_EN adds a RUN-state abort input.
//
// bquadblk: combinational o_out = in^(2^i_sel), in forced to zero when
// i_en=0 so the squaring network does not toggle while idle.
//   i_en  : input gate
//   i_in  : operand
//   i_sel : number of squarings (0..15)
//   o_out : result

module bquadblk (
  input  logic         i_en,
  input  logic [232:0] i_in,
  input  logic [3:0]   i_sel,
  output logic [232:0] o_out
);
  // Squaring is linear: spread bits to even positions, then fold bits
  // 464..233 back with x^233 = x^74 + 1. Folding from the top down lets a
  // folded bit that lands above 232 be folded again later in the loop.
  function automatic logic [232:0] gf_sqr(input logic [232:0] a);
    logic [464:0] s;
    s = '0;
    for (int unsigned i = 0; i < 233; i++) s[2*i] = a[i];
    for (int unsigned i = 464; i >= 233; i--) begin
      if (s[i]) begin
        s[i-233] = ~s[i-233];
        s[i-159] = ~s[i-159];
      end
    end
    return s[232:0];
  endfunction

  logic [232:0] w_pow [0:15];

  always_comb begin
    w_pow[0] = i_en ? i_in : '0;
    for (int unsigned k = 1; k < 16; k++) w_pow[k] = gf_sqr(w_pow[k-1]);
  end

  assign o_out = w_pow[i_sel];
endmodule

module bquad_pow_seq #(
  parameter int MAX_STEP = 15,
  parameter int NW       = 8
) (
  input logic            clk,
  input logic            rst,
  bquad_pow_seq_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [232:0]  r_acc;
  logic [NW-1:0] r_rem;
  logic [232:0]  r_result;

  logic          w_run;
  logic          w_accept;
  logic          w_abort;
  logic [3:0]    w_step;
  logic [NW-1:0] w_rem_nxt;
  logic [232:0]  w_quad_out;
  logic [3:0]    w_sel;

`ifdef BQSEQ_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_run     = (r_state == S_RUN);
  assign w_accept  = bus.start && (r_state != S_RUN);
  assign w_step    = (r_rem > NW'(MAX_STEP)) ? 4'(MAX_STEP) : r_rem[3:0];
  assign w_rem_nxt = r_rem - NW'(w_step);
  assign w_sel     = w_run ? w_step : '0;

  bquadblk u_quad (
    .i_en  (w_run),
    .i_in  (r_acc),
    .i_sel (w_sel),
    .o_out (w_quad_out)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_state_nxt = (bus.n_in == '0) ? S_DONE : S_RUN;
        else           w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_abort)                w_state_nxt = S_IDLE;
        else if (w_rem_nxt == '0)   w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc <= bus.a_in;
      r_rem <= bus.n_in;
      if (bus.n_in == '0) r_result <= bus.a_in;
    end else if (w_run && !w_abort) begin
      r_acc <= w_quad_out;
      r_rem <= w_rem_nxt;
      if (w_rem_nxt == '0) r_result <= w_quad_out;
    end
  end

  assign bus.busy   = w_run;
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
endmodule

// File: tb/tb_bquad_pow_seq.sv
module tb_bquad_pow_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bquad_pow_seq_if #(.NW(8)) bus_if ();

  bquad_pow_seq #(.MAX_STEP(15), .NW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [232:0] obs, input logic [232:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: generic shift-and-add multiply modulo x^233+x^74+1.
  function automatic logic [232:0] m_xtime(input logic [232:0] v);
    logic c;
    c = v[232];
    v = v << 1;
    if (c) begin
      v[0]  = ~v[0];
      v[74] = ~v[74];
    end
    return v;
  endfunction

  function automatic logic [232:0] m_mul(input logic [232:0] a, input logic [232:0] b);
    logic [232:0] r;
    r = '0;
    for (int i = 232; i >= 0; i--) begin
      r = m_xtime(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [232:0] m_pow2n(input logic [232:0] a, input int n);
    for (int i = 0; i < n; i++) a = m_mul(a, a);
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [232:0] a, input logic [7:0] n);
    bus_if.start = 1'b1;
    bus_if.a_in  = a;
    bus_if.n_in  = n;
    tick();
    bus_if.start = 1'b0;
  endtask

  // Counts edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (bus_if.done !== 1'b1 && cyc < 100) begin
      if (bus_if.busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    logic [232:0] e;
    logic [232:0] ra;
    logic [232:0] keep;
    int cyc;
    int bc;
    int dcnt;

    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a_in  = '0;
    bus_if.n_in  = '0;
`ifdef BQSEQ_ABORT_EN
    bus_if.abort = 1'b0;
`endif
    tick(); tick(); tick();
    check("rst_busy", 233'(bus_if.busy), 233'(0));
    check("rst_done", 233'(bus_if.done), 233'(0));
    check("rst_result", bus_if.result, '0);
    rst = 1'b0;
    tick();

    // n = 0: result is the operand, done right after the accepting edge
    start_op(233'h1AB, 8'd0);
    check("zero_done", 233'(bus_if.done), 233'(1));
    check("zero_busy", 233'(bus_if.busy), 233'(0));
    check("zero_result", bus_if.result, 233'h1AB);
    tick();
    check("zero_pulse", 233'(bus_if.done), 233'(0));
    check("zero_hold", bus_if.result, 233'h1AB);

    // x^(2^7) = x^128, one pass
    start_op(233'h2, 8'd7);
    wait_done(cyc, bc);
    e = '0; e[128] = 1'b1;
    check("n7_cycles", 233'(cyc), 233'(1));
    check("n7_busy", 233'(bc), 233'(1));
    check("n7_result", bus_if.result, e);
    tick();
    check("n7_pulse", 233'(bus_if.done), 233'(0));

    // n = 16 splits into 15 + 1
    start_op(233'h2, 8'd16);
    wait_done(cyc, bc);
    check("n16_cycles", 233'(cyc), 233'(2));
    check("n16_result", bus_if.result, m_pow2n(233'h2, 16));
    tick();

    // full chain with stray starts mid-run
    ra = '0;
    for (int i = 0; i < 8; i++) ra = {ra[200:0], 32'($urandom)};
    start_op(ra, 8'd232);
    cyc = 0;
    while (bus_if.done !== 1'b1 && cyc < 100) begin
      if (cyc == 3 || cyc == 9) begin
        bus_if.start = 1'b1;
        bus_if.a_in  = ~ra;
        bus_if.n_in  = 8'd5;
      end else begin
        bus_if.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus_if.start = 1'b0;
    check("n232_cycles", 233'(cyc), 233'(16));
    check("n232_result", bus_if.result, m_pow2n(ra, 232));
    check("n232_inverse", m_mul(bus_if.result, bus_if.result), ra);

    // back-to-back: start in the DONE cycle
    start_op(233'h1, 8'd100);
    check("b2b_busy", 233'(bus_if.busy), 233'(1));
    wait_done(cyc, bc);
    check("b2b_cycles", 233'(cyc), 233'(7));
    check("b2b_result", bus_if.result, 233'h1);
    tick();

    // reset in cycle 3 of a 16-cycle run
    start_op(ra, 8'd232);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 233'(bus_if.busy), 233'(0));
    check("midrst_done", 233'(bus_if.done), 233'(0));
    check("midrst_result", bus_if.result, '0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.done === 1'b1) dcnt++;
      tick();
    end
    check("midrst_nodone", 233'(dcnt), 233'(0));

    start_op(233'h2, 8'd1);
    wait_done(cyc, bc);
    e = '0; e[2] = 1'b1;
    check("postrst_cycles", 233'(cyc), 233'(1));
    check("postrst_result", bus_if.result, e);
    tick();

`ifdef BQSEQ_ABORT_EN
    keep = bus_if.result;
    start_op(ra, 8'd232);
    tick(); tick(); tick();
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check("abort_busy", 233'(bus_if.busy), 233'(0));
    check("abort_done", 233'(bus_if.done), 233'(0));
    check("abort_result", bus_if.result, keep);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.done === 1'b1) dcnt++;
      tick();
    end
    check("abort_nodone", 233'(dcnt), 233'(0));
    // abort together with start while idle: start wins
    bus_if.abort = 1'b1;
    start_op(233'h20, 8'd3);
    bus_if.abort = 1'b0;
    check("abort_start_busy", 233'(bus_if.busy), 233'(1));
    wait_done(cyc, bc);
    e = '0; e[40] = 1'b1;
    check("abort_after_cycles", 233'(cyc), 233'(1));
    check("abort_after_result", bus_if.result, e);
    tick();
`else
    keep = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bquad_pow_seq.md
Name: bquad_pow_seq

Overview:
- Multi-cycle sequencer that computes a^(2^n) in GF(2^233), field polynomial x^233+x^74+1, for n = 0..255.
- Chains passes through a single internal bquadblk instance. Each pass raises the operand to 2^step, with step <= MAX_STEP.
- Serves the Itoh-Tsujii inversion control path and any caller needing long squaring chains. Gates the quadblock input to zero when idle.

Parameters:
- MAX_STEP, 15, largest sel value issued to the quadblock per cycle (1..15).
- NW, 8, width of the exponent-count input n_in.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request: sampled only when busy=0
- a_in  input  233  field element operand, captured on accepted start
- n_in  input  NW  number of squarings n, captured on accepted start
- busy  output  1  high while squaring passes are in progress
- done  output  1  single-cycle pulse: result valid
- result  output  233  a^(2^n); held stable from done until the next accepted start

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, acc=0, rem=0, quadblock en=0.
- Reset mid-run: aborts with no done pulse; next start is accepted normally.
- States: IDLE, RUN, DONE.
- IDLE, start=1: acc<=a_in, rem<=n_in.
  - n_in=0: go to DONE; result<=a_in.
  - else: go to RUN.
- RUN:
  - step = (rem > MAX_STEP) ? MAX_STEP : rem[3:0].
  - Quadblock driven with en=1, in=acc, sel=step.
  - Each edge: acc<=quad_out, rem<=rem-step.
  - If rem-step==0: result<=quad_out, go to DONE. Else stay in RUN.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - start=1 while in DONE is accepted as in IDLE, so back-to-back operations are supported.
- busy: 1 in RUN only. Accepted start with n_in!=0 makes busy=1 on the next cycle.
- Latency: done asserts ceil(n/MAX_STEP) cycles after the accepting edge; 1 cycle when n=0. With MAX_STEP=15, n=232 takes 16 cycles.
- start while busy=1 is ignored; a_in and n_in are not sampled.
- Quadblock en=0 outside RUN, which forces its input to zero (no toggling while idle).
- sel is never 0 in RUN.
- rem never underflows: step <= rem by construction.
- Arithmetic: rem is NW bits unsigned.
- result changes only on the DONE transition or on reset.

Optional Feature:
- Macro: BQSEQ_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in RUN on a clock edge: go to IDLE next cycle, busy=0, no done pulse, result unchanged.
  - abort in IDLE or DONE: no effect; the done pulse still occurs.
  - abort and start together in IDLE: start wins.
- Undefined: no abort port; RUN always completes.

Test Plan:
- Zero count: reset, start with a_in=0x1AB (bits 0,1,3,5,7,8), n_in=0 -> done 1 cycle later, result=0x1AB, busy never high.
- Single-step chain: a_in=x (bit 1), n_in=7 -> busy 1 cycle, done next cycle, result has only bit 128 set.
- Step-boundary split: a_in=x, n_in=16 -> 2 RUN cycles (sel 15 then 1), result equals the software model of x^(2^16) mod x^233+x^74+1.
- Full-length chain: random a, n_in=232 -> done after 16 cycles; squaring the result once in the model equals a; start pulses during busy are ignored, with a_in/n_in changed mid-run to catch bad sampling.
- Back-to-back operation: start asserted in the DONE cycle with a_in=1, n_in=100 -> new operation accepted, result=1 after 7 cycles; rst asserted in cycle 3 of a 16-cycle run -> busy=0, done=0, result=0 next cycle, no done pulse.
- Abort (BQSEQ_ABORT_EN): abort at RUN cycle 4 of n=232 -> IDLE next cycle, no done, result keeps previous value; a subsequent start completes correctly.
